// File: rtl/branch_resolve_queue_if.sv
// Fetch-allocate / EX-resolve bundle for the branch resolve queue.
// Master drives allocations and resolves; slave returns predictor updates.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                       alloc_valid;
  logic                       alloc_pred_taken;
  logic [31:0]                alloc_pred_target;
  logic [31:0]                alloc_fallthru;
  logic                       alloc_choose_G;
  logic [4:0]                 alloc_index;
  logic [4:0]                 alloc_GHR;
  logic                       alloc_ready;
  logic                       resolve_valid;
  logic                       resolve_taken;
  logic [31:0]                resolve_target;
  logic                       upd_valid;
  logic                       upd_taken;
  logic                       upd_choose_G;
  logic [4:0]                 upd_index;
  logic [4:0]                 upd_GHR;
  logic                       mispredict;
  logic [31:0]                redirect_pc;
  logic [CNT_W-1:0]           mispredict_count;
  logic [$clog2(DEPTH):0]     occupancy;
  logic                       underflow_err;

  modport master (
    output alloc_valid, alloc_pred_taken, alloc_pred_target,
    output alloc_fallthru, alloc_choose_G, alloc_index, alloc_GHR,
    output resolve_valid, resolve_taken, resolve_target,
    input  alloc_ready, upd_valid, upd_taken, upd_choose_G,
    input  upd_index, upd_GHR, mispredict, redirect_pc,
    input  mispredict_count, occupancy, underflow_err
  );

  modport slave (
    input  alloc_valid, alloc_pred_taken, alloc_pred_target,
    input  alloc_fallthru, alloc_choose_G, alloc_index, alloc_GHR,
    input  resolve_valid, resolve_taken, resolve_target,
    output alloc_ready, upd_valid, upd_taken, upd_choose_G,
    output upd_index, upd_GHR, mispredict, redirect_pc,
    output mispredict_count, occupancy, underflow_err
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves the head against EX,
// emits predictor updates and flushes on a misprediction.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   Reset,
  branch_resolve_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic        pt;
    logic [31:0] tgt;
    logic [31:0] ft;
    logic        cg;
    logic [4:0]  idx;
    logic [4:0]  ghr;
  } ent_t;

  ent_t             r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_occ;
  logic             r_upd_valid;
  logic             r_upd_taken;
  logic             r_upd_cg;
  logic [4:0]       r_upd_idx;
  logic [4:0]       r_upd_ghr;
  logic             r_mis;
  logic [31:0]      r_rpc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_uf;

  ent_t w_head;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_mis;
  logic w_push;

  assign w_head  = r_mem[r_rptr];
  assign w_full  = (r_occ == FULL);
  assign w_empty = (r_occ == '0);
  assign w_pop   = bus.resolve_valid && !w_empty;
  assign w_mis   = w_pop &&
                   ((w_head.pt != bus.resolve_taken) ||
                    (bus.resolve_taken &&
                     (w_head.tgt != bus.resolve_target)));
  // A pop frees the head slot, so a full queue still takes the push
  assign w_push  = bus.alloc_valid && !w_mis && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= '{pt:  bus.alloc_pred_taken,
                         tgt: bus.alloc_pred_target,
                         ft:  bus.alloc_fallthru,
                         cg:  bus.alloc_choose_G,
                         idx: bus.alloc_index,
                         ghr: bus.alloc_GHR};
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else if (w_mis) begin
      r_rptr <= r_wptr;
      r_occ  <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_occ <= r_occ + 1'b1;
      else if (!w_push && w_pop)
        r_occ <= r_occ - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_upd_valid <= 1'b0;
      r_upd_taken <= 1'b0;
      r_upd_cg    <= 1'b0;
      r_upd_idx   <= '0;
      r_upd_ghr   <= '0;
      r_mis       <= 1'b0;
      r_rpc       <= '0;
      r_cnt       <= '0;
      r_uf        <= 1'b0;
    end else begin
      r_upd_valid <= w_pop;
      r_mis       <= w_mis;
      if (w_pop) begin
        r_upd_taken <= bus.resolve_taken;
        r_upd_cg    <= w_head.cg;
        r_upd_idx   <= w_head.idx;
        r_upd_ghr   <= w_head.ghr;
        r_rpc       <= bus.resolve_taken ? bus.resolve_target
                                         : w_head.ft;
      end
      if (w_mis && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
      if (bus.resolve_valid && w_empty)
        r_uf <= 1'b1;
    end
  end

  assign bus.alloc_ready      = !w_full;
  assign bus.occupancy        = r_occ;
  assign bus.upd_valid        = r_upd_valid;
  assign bus.upd_taken        = r_upd_taken;
  assign bus.upd_choose_G     = r_upd_cg;
  assign bus.upd_index        = r_upd_idx;
  assign bus.upd_GHR          = r_upd_ghr;
  assign bus.mispredict       = r_mis;
  assign bus.redirect_pc      = r_rpc;
  assign bus.mispredict_count = r_cnt;
  assign bus.underflow_err    = r_uf;
endmodule
